// File: rtl/pipe_stall_ctrl.sv
// Central staller for a 5-stage RISC-V core: arbitrates the single memory port
// between fetch and load/store and issues per-stage GO/STALL/BUBBLE codes.
module pipe_stall_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        dclk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        jump_i,
    input  logic        ld_use_i,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_ack_i,
    input  logic [31:0] ram_rdata_i,
    output logic        if_ack_o,
    output logic        mem_ack_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  stl_pc_o,
    output logic [1:0]  stl_ifid_o,
    output logic [1:0]  stl_idex_o,
    output logic [1:0]  stl_exmem_o,
    output logic [1:0]  stl_memwb_o,
    output logic        err_o
);

    localparam logic [1:0] GO     = 2'b00;
    localparam logic [1:0] STALL  = 2'b01;
    localparam logic [1:0] BUBBLE = 2'b10;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        IF_WAIT  = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic        drop_q, drop_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic in_idle_s, in_if_s, in_mem_s;
    logic if_ack_s, mem_wait_s, fetch_pend_s;

    // State and request registers
    always_ff @(posedge dclk) begin
        if (rst) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Arbitration, request capture, wait counter and drop tracking
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    state_d = MEM_WAIT;
                    req_d   = 1'b1;
                    we_d    = mem_we_i;
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                end else if (if_req_i) begin
                    state_d = IF_WAIT;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = if_addr_i;
                    wdata_d = 32'd0;
                    drop_d  = jump_i;
                end else begin
                    state_d = IDLE;
                end
            end
            IF_WAIT, MEM_WAIT: begin
                if (ram_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    cnt_d   = 8'd0;
                    drop_d  = 1'b0;
                end else begin
                    // Saturate so a stuck memory cannot wrap the counter past the limit
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (cnt_d == TIMEOUT_C) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if ((state_q == IF_WAIT) && jump_i) begin
                        drop_d = 1'b1;
                    end else begin
                        drop_d = drop_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_idle_s    = (state_q == IDLE);
    assign in_if_s      = (state_q == IF_WAIT);
    assign in_mem_s     = (state_q == MEM_WAIT);
    assign if_ack_s     = in_if_s & ram_ack_i & ~drop_q & ~jump_i;
    assign mem_wait_s   = (in_idle_s & mem_req_i) | (in_mem_s & ~ram_ack_i);
    assign fetch_pend_s = (in_if_s & ~if_ack_s) | (in_idle_s & if_req_i);

    // Acks and prioritised stall codes
    always_comb begin
        if_ack_o    = 1'b0;
        mem_ack_o   = 1'b0;
        stl_pc_o    = GO;
        stl_ifid_o  = GO;
        stl_idex_o  = GO;
        stl_exmem_o = GO;
        stl_memwb_o = GO;
        if (!rst) begin
            if_ack_o  = if_ack_s;
            mem_ack_o = in_mem_s & ram_ack_i;
            if (mem_wait_s) begin
                stl_pc_o    = STALL;
                stl_ifid_o  = STALL;
                stl_idex_o  = STALL;
                stl_exmem_o = STALL;
                stl_memwb_o = BUBBLE;
            end else if (jump_i) begin
                stl_ifid_o  = BUBBLE;
                stl_idex_o  = BUBBLE;
            end else if (ld_use_i) begin
                stl_pc_o    = STALL;
                stl_ifid_o  = STALL;
                stl_idex_o  = BUBBLE;
            end else if (fetch_pend_s) begin
                stl_pc_o    = STALL;
                stl_ifid_o  = BUBBLE;
            end else begin
                stl_pc_o    = GO;
            end
        end else begin
            if_ack_o  = 1'b0;
            mem_ack_o = 1'b0;
        end
    end

    assign ram_req_o   = req_q;
    assign ram_we_o    = we_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign rdata_o     = ram_rdata_i;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a transaction-level memory/pipeline
// model predicts per-cycle codes, issued requests and returned data.
module tb_pipe_stall_ctrl;

    localparam int TMO = 4;
    localparam logic [1:0] GO     = 2'b00;
    localparam logic [1:0] STALL  = 2'b01;
    localparam logic [1:0] BUBBLE = 2'b10;

    logic        dclk = 1'b0;
    logic        rst;
    logic        if_req_i, mem_req_i, mem_we_i, jump_i, ld_use_i, ram_ack_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i, ram_rdata_i;
    logic        ram_req_o, ram_we_o, if_ack_o, mem_ack_o, err_o;
    logic [31:0] ram_addr_o, ram_wdata_o, rdata_o;
    logic [1:0]  stl_pc_o, stl_ifid_o, stl_idex_o, stl_exmem_o, stl_memwb_o;

    always #5 dclk = ~dclk;

    pipe_stall_ctrl #(.TIMEOUT(TMO)) dut (
        .dclk(dclk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .jump_i(jump_i), .ld_use_i(ld_use_i),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_ack_i(ram_ack_i), .ram_rdata_i(ram_rdata_i),
        .if_ack_o(if_ack_o), .mem_ack_o(mem_ack_o), .rdata_o(rdata_o),
        .stl_pc_o(stl_pc_o), .stl_ifid_o(stl_ifid_o), .stl_idex_o(stl_idex_o),
        .stl_exmem_o(stl_exmem_o), .stl_memwb_o(stl_memwb_o),
        .err_o(err_o)
    );

    typedef struct {
        bit          is_mem;
        bit          dropped;
        int          waited;
    } txn_t;

    typedef struct {
        logic [1:0]  pc, ifid, idex, exmem, memwb;
        logic        if_ack, mem_ack, req, we, err;
        logic [31:0] addr, wdata;
    } cyc_t;

    typedef struct {
        logic        we;
        logic [31:0] addr, wdata;
    } req_t;

    typedef struct {
        logic        is_mem;
        logic [31:0] rdata;
    } rsp_t;

    txn_t outst[$];
    cyc_t cyc_q[$];
    req_t req_q[$];
    rsp_t rsp_q[$];

    bit          m_err;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        if_req_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        jump_i = 1'b0; ld_use_i = 1'b0; ram_ack_i = 1'b0;
        if_addr_i = 32'd0; mem_addr_i = 32'd0; mem_wdata_i = 32'd0;
        ram_rdata_i = 32'd0;
    endtask

    // One clock of stimulus: predict this cycle's outputs, then advance the model.
    task automatic step();
        cyc_t e;
        bit   busy, cur_mem, cur_drop, mem_wait, fetch_pend;
        txn_t t;
        busy = (outst.size() != 0);
        cur_mem = 1'b0;
        cur_drop = 1'b0;
        if (busy) begin
            cur_mem  = outst[0].is_mem;
            cur_drop = outst[0].dropped;
        end
        e.req = busy; e.we = m_we; e.addr = m_addr; e.wdata = m_wdata; e.err = m_err;
        e.pc = GO; e.ifid = GO; e.idex = GO; e.exmem = GO; e.memwb = GO;
        e.if_ack = 1'b0; e.mem_ack = 1'b0;
        if (!rst) begin
            e.mem_ack  = busy && cur_mem && ram_ack_i;
            e.if_ack   = busy && !cur_mem && ram_ack_i && !cur_drop && !jump_i;
            mem_wait   = (!busy && mem_req_i) || (busy && cur_mem && !ram_ack_i);
            fetch_pend = (busy && !cur_mem && !e.if_ack) || (!busy && if_req_i);
            if (mem_wait) begin
                e.pc = STALL; e.ifid = STALL; e.idex = STALL; e.exmem = STALL; e.memwb = BUBBLE;
            end else if (jump_i) begin
                e.ifid = BUBBLE; e.idex = BUBBLE;
            end else if (ld_use_i) begin
                e.pc = STALL; e.ifid = STALL; e.idex = BUBBLE;
            end else if (fetch_pend) begin
                e.pc = STALL; e.ifid = BUBBLE;
            end
            if (e.mem_ack || e.if_ack)
                rsp_q.push_back('{is_mem: e.mem_ack, rdata: ram_rdata_i});
        end
        cyc_q.push_back(e);
        @(posedge dclk);
        if (rst) begin
            outst.delete();
            m_err = 1'b0; m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
        end else if (busy) begin
            if (ram_ack_i) begin
                void'(outst.pop_front());
            end else begin
                t = outst[0];
                t.waited = t.waited + 1;
                if (t.waited == TMO) m_err = 1'b1;
                if (!t.is_mem && jump_i) t.dropped = 1'b1;
                outst[0] = t;
            end
        end else if (mem_req_i) begin
            outst.push_back('{is_mem: 1'b1, dropped: 1'b0, waited: 0});
            m_we = mem_we_i; m_addr = mem_addr_i; m_wdata = mem_wdata_i;
            req_q.push_back('{we: m_we, addr: m_addr, wdata: m_wdata});
        end else if (if_req_i) begin
            outst.push_back('{is_mem: 1'b0, dropped: jump_i, waited: 0});
            m_we = 1'b0; m_addr = if_addr_i; m_wdata = 32'd0;
            req_q.push_back('{we: m_we, addr: m_addr, wdata: m_wdata});
        end
        #1;
    endtask

    logic prev_req = 1'b0;
    cyc_t mc;
    req_t mr;
    rsp_t ms;

    // Monitor: compares the DUT against the predicted per-cycle, request and response queues
    always @(negedge dclk) begin
        if (cyc_q.size() != 0) begin
            mc = cyc_q.pop_front();
            chk("stl_pc",    {30'd0, stl_pc_o},    {30'd0, mc.pc});
            chk("stl_ifid",  {30'd0, stl_ifid_o},  {30'd0, mc.ifid});
            chk("stl_idex",  {30'd0, stl_idex_o},  {30'd0, mc.idex});
            chk("stl_exmem", {30'd0, stl_exmem_o}, {30'd0, mc.exmem});
            chk("stl_memwb", {30'd0, stl_memwb_o}, {30'd0, mc.memwb});
            chk("if_ack",    {31'd0, if_ack_o},    {31'd0, mc.if_ack});
            chk("mem_ack",   {31'd0, mem_ack_o},   {31'd0, mc.mem_ack});
            chk("ram_req",   {31'd0, ram_req_o},   {31'd0, mc.req});
            chk("ram_we",    {31'd0, ram_we_o},    {31'd0, mc.we});
            chk("ram_addr",  ram_addr_o,           mc.addr);
            chk("ram_wdata", ram_wdata_o,          mc.wdata);
            chk("err",       {31'd0, err_o},       {31'd0, mc.err});
        end
        if (ram_req_o && !prev_req) begin
            if (req_q.size() == 0) begin
                chk("req_unexpected", 32'd1, 32'd0);
            end else begin
                mr = req_q.pop_front();
                chk("grant_we",    {31'd0, ram_we_o}, {31'd0, mr.we});
                chk("grant_addr",  ram_addr_o,        mr.addr);
                chk("grant_wdata", ram_wdata_o,       mr.wdata);
            end
        end
        prev_req = ram_req_o;
        if (if_ack_o || mem_ack_o) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                ms = rsp_q.pop_front();
                chk("rsp_kind",  {31'd0, mem_ack_o}, {31'd0, ms.is_mem});
                chk("rsp_rdata", rdata_o,            ms.rdata);
            end
        end
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        m_err = 1'b0; m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
        @(posedge dclk); #1;
        step(); step();
        rst = 1'b0;
        step();

        // load acked after three wait cycles
        mem_req_i = 1'b1; mem_addr_i = 32'h0000_0100;
        repeat (4) step();
        ram_ack_i = 1'b1; ram_rdata_i = 32'hDEAD_BEEF;
        step();
        clear_inputs(); step();

        // simultaneous fetch and store: store wins, fetch follows
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0200;
        mem_wdata_i = 32'hCAFE_F00D; if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
        step(); step();
        ram_ack_i = 1'b1; step();
        ram_ack_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        step(); step();
        ram_ack_i = 1'b1; ram_rdata_i = 32'h1234_5678; step();
        clear_inputs(); step();

        // jump while a fetch is outstanding: fetched word dropped, refetch from target
        if_req_i = 1'b1; if_addr_i = 32'h0000_0044; step();
        jump_i = 1'b1; step();
        jump_i = 1'b0; step();
        ram_ack_i = 1'b1; ram_rdata_i = 32'h0BAD_0BAD; step();
        ram_ack_i = 1'b0; if_addr_i = 32'h0000_0080; step(); step();
        ram_ack_i = 1'b1; ram_rdata_i = 32'h0000_0013; step();
        clear_inputs(); step();

        // load-use alone, then with a jump
        ld_use_i = 1'b1; step();
        jump_i = 1'b1; step();
        clear_inputs(); step();

        // reset mid-wait, late ack afterwards is ignored
        mem_req_i = 1'b1; mem_addr_i = 32'h0000_0300; step(); step();
        rst = 1'b1; step();
        rst = 1'b0; mem_req_i = 1'b0; ram_ack_i = 1'b1; step();
        ram_ack_i = 1'b0; step();

        // memory never answers: sticky timeout, request held
        mem_req_i = 1'b1; mem_addr_i = 32'h0000_0400; step();
        repeat (8) step();
        rst = 1'b1; step();
        rst = 1'b0; clear_inputs(); step();

        repeat (3000) begin
            rst         = ($urandom_range(0, 99) < 2);
            mem_req_i   = ($urandom_range(0, 99) < 30);
            mem_we_i    = $urandom_range(0, 1) == 1;
            mem_addr_i  = $urandom;
            mem_wdata_i = $urandom;
            if_req_i    = ($urandom_range(0, 99) < 60);
            if_addr_i   = $urandom;
            jump_i      = ($urandom_range(0, 99) < 15);
            ld_use_i    = ($urandom_range(0, 99) < 15);
            ram_rdata_i = $urandom;
            if (outst.size() != 0) ram_ack_i = ($urandom_range(0, 99) < 35);
            else                   ram_ack_i = ($urandom_range(0, 99) < 8);
            step();
        end

        rst = 1'b0; clear_inputs();
        step(); step();
        @(negedge dclk); #1;
        chk("cyc_q_drained", cyc_q.size(), 32'd0);
        chk("req_q_drained", req_q.size(), 32'd0);
        chk("rsp_q_drained", rsp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
